// File: rtl/wide_add_sequencer.sv
// wide_add_sequencer: WIDTH-bit add through one CHUNK-bit carry-select slice, LSB chunk first.
// Optional subtract mode and signed-overflow flag under macro WIDE_ADD_SEQ_SUB_EN.
module wide_add_sequencer #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef WIDE_ADD_SEQ_SUB_EN
  ,
  input  logic             op_sub,
  output logic             ovf
`endif
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  if (WIDTH % CHUNK != 0 || NCHUNK < 2) begin : g_bad_params
    $error("wide_add_sequencer: WIDTH must be a multiple of CHUNK with at least two chunks");
  end
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             carry_q, carry_d, cout_q, cout_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CHUNK-1:0] ca, cb;
  logic [CHUNK:0]   s0, s1, slice;
  logic             sub_in, last;
`ifdef WIDE_ADD_SEQ_SUB_EN
  assign sub_in = op_sub;
`else
  assign sub_in = 1'b0;
`endif
  // Both carry outcomes are formed up front; the held carry only picks one.
  always_comb begin
    ca = a_q[idx_q*CHUNK +: CHUNK];
    cb = b_q[idx_q*CHUNK +: CHUNK];
    s0 = {1'b0, ca} + {1'b0, cb};
    s1 = {1'b0, ca} + {1'b0, cb} + (CHUNK+1)'(1);
    slice = carry_q ? s1 : s0;
  end
  assign last = idx_q == IW'(NCHUNK - 1);
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    carry_d = carry_q;
    idx_d = idx_q;
    sum_d = sum_q;
    cout_d = cout_q;
    case (state_q)
      IDLE: if (in_valid) begin
        a_d = a;
        b_d = sub_in ? ~b : b;
        carry_d = sub_in | cin;
        idx_d = '0;
        state_d = RUN;
      end
      RUN: begin
        sum_d[idx_q*CHUNK +: CHUNK] = slice[CHUNK-1:0];
        carry_d = slice[CHUNK];
        idx_d = idx_q + 1'b1;
        if (last) begin
          cout_d = slice[CHUNK];
          state_d = DONE;
        end
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      carry_q <= 1'b0;
      idx_q <= '0;
      sum_q <= '0;
      cout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      carry_q <= carry_d;
      idx_q <= idx_d;
      sum_q <= sum_d;
      cout_q <= cout_d;
    end
  end
`ifdef WIDE_ADD_SEQ_SUB_EN
  logic ovf_q, ovf_d;
  // b_q already holds the effective (possibly inverted) operand, so one rule covers add and sub.
  assign ovf_d = (state_q == RUN && last) ?
                 (a_q[WIDTH-1] == b_q[WIDTH-1]) && (slice[CHUNK-1] != a_q[WIDTH-1]) : ovf_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else ovf_q <= ovf_d;
  end
  assign ovf = ovf_q;
`endif
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign busy = state_q != IDLE;
  assign sum = sum_q;
  assign cout = cout_q;
endmodule

// File: tb/tb_wide_add_sequencer.sv
// tb_wide_add_sequencer: randomized and directed checks of wide_add_sequencer against a plain-arithmetic model.
module tb_wide_add_sequencer;
  logic        clk = 0, rst_n = 0, in_valid = 0, out_ready = 0, cin = 0;
  logic [31:0] a = 0, b = 0;
  logic        in_ready, out_valid, cout, busy;
  logic [31:0] sum;
`ifdef WIDE_ADD_SEQ_SUB_EN
  logic op_sub = 0;
  logic ovf;
`endif
  int total = 0, bad = 0;

  wide_add_sequencer #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
`ifdef WIDE_ADD_SEQ_SUB_EN
    , .op_sub(op_sub), .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [32:0] ref_add(input logic [31:0] x, input logic [31:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + 33'(c);
  endfunction

  // Presents one operation, then counts edges after the accepting edge until out_valid (-1 on timeout).
  task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic ic, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    a = ia; b = ib; cin = ic; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    a = $urandom; b = $urandom; cin = 1'($urandom);
    lat = -1;
    for (int i = 1; i <= 20 && lat < 0; i++) begin
      @(posedge clk); #1;
      if (out_valid) lat = i;
    end
  endtask

  task automatic handshake;
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
  endtask

  task automatic test_reset;
    #3;
    total++; if ({in_ready, out_valid, busy, cout, sum} !== {3'b100, 33'h0}) begin bad++; $display("FAIL reset_async got=%b_%h exp=1000_0", {in_ready, out_valid, busy, cout}, sum); end
    #9 rst_n = 1;
    @(posedge clk); #1;
    total++; if ({in_ready, out_valid, busy} !== 3'b100) begin bad++; $display("FAIL reset_release got=%b exp=100", {in_ready, out_valid, busy}); end
  endtask

  task automatic test_directed;
    logic [31:0] ta[2] = '{32'h1, 32'hFFFFFFFF};
    logic [31:0] tb_[2] = '{32'h1, 32'h1};
    logic [31:0] es[2] = '{32'h2, 32'h0};
    logic        ec[2] = '{1'b0, 1'b1};
    int lat;
    for (int k = 0; k < 2; k++) begin
      issue(ta[k], tb_[k], 1'b0, lat);
      total++; if (lat !== 4) begin bad++; $display("FAIL t%0d_latency got=%0d exp=4", k + 1, lat); end
      total++; if (sum !== es[k]) begin bad++; $display("FAIL t%0d_sum got=%h exp=%h", k + 1, sum, es[k]); end
      total++; if (cout !== ec[k]) begin bad++; $display("FAIL t%0d_cout got=%b exp=%b", k + 1, cout, ec[k]); end
      handshake;
      total++; if ({out_valid, in_ready} !== 2'b01) begin bad++; $display("FAIL t%0d_release got=%b exp=01", k + 1, {out_valid, in_ready}); end
    end
  endtask

  task automatic test_backpressure;
    int lat;
    issue(32'h7C7C7C7C, 32'h83838383, 1'b1, lat);
    total++; if ({cout, sum} !== 33'h1_00000000 || lat !== 4) begin bad++; $display("FAIL t3_result got=%b_%h lat=%0d exp=1_00000000 lat=4", cout, sum, lat); end
    for (int i = 0; i < 10; i++) begin
      in_valid = 1; a = $urandom; b = $urandom; cin = 1'($urandom);
      @(posedge clk); #1;
      total++; if ({out_valid, in_ready, cout, sum} !== {3'b101, 32'h0}) begin bad++; $display("FAIL t3_hold%0d got=%b_%h exp=101_00000000", i, {out_valid, in_ready, cout}, sum); end
    end
    in_valid = 0;
    handshake;
    @(posedge clk); #1;
    total++; if ({busy, out_valid, in_ready} !== 3'b001) begin bad++; $display("FAIL t3_not_queued got=%b exp=001", {busy, out_valid, in_ready}); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] x1, y1, x2, y2;
    logic c1, c2;
    logic [32:0] e;
    int lat;
    x1 = $urandom; y1 = $urandom; c1 = 1'($urandom);
    x2 = $urandom; y2 = $urandom; c2 = 1'($urandom);
    issue(x1, y1, c1, lat);
    e = ref_add(x1, y1, c1);
    total++; if ({cout, sum} !== e) begin bad++; $display("FAIL t4_first got=%h exp=%h", {cout, sum}, e); end
    a = x2; b = y2; cin = c2; in_valid = 1; out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    total++; if ({out_valid, in_ready} !== 2'b01) begin bad++; $display("FAIL t4_handshake_only got=%b exp=01", {out_valid, in_ready}); end
    @(posedge clk); #1;
    in_valid = 0; a = $urandom; b = $urandom;
    total++; if ({busy, in_ready} !== 2'b10) begin bad++; $display("FAIL t4_accept got=%b exp=10", {busy, in_ready}); end
    lat = -1;
    for (int i = 1; i <= 20 && lat < 0; i++) begin @(posedge clk); #1; if (out_valid) lat = i; end
    e = ref_add(x2, y2, c2);
    total++; if (lat !== 4) begin bad++; $display("FAIL t4_latency got=%0d exp=4", lat); end
    total++; if ({cout, sum} !== e) begin bad++; $display("FAIL t4_second got=%h exp=%h", {cout, sum}, e); end
    handshake;
  endtask

  task automatic test_reset_mid_run;
    int lat;
    a = 32'h01010101; b = 32'h01010101; cin = 0; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    @(posedge clk); @(posedge clk); #2;
    rst_n = 0;
    #1;
    total++; if ({in_ready, out_valid, busy, cout, sum} !== {3'b100, 33'h0}) begin bad++; $display("FAIL t5_abort got=%b_%h exp=1000_0", {in_ready, out_valid, busy, cout}, sum); end
    #10 rst_n = 1;
    @(posedge clk); #1;
    issue(32'hAAAAAAAA, 32'h55555555, 1'b0, lat);
    total++; if ({cout, sum} !== 33'h0_FFFFFFFF || lat !== 4) begin bad++; $display("FAIL t5_after got=%h lat=%0d exp=0ffffffff lat=4", {cout, sum}, lat); end
    handshake;
  endtask

  task automatic test_random;
    logic [31:0] x, y;
    logic c;
    logic [32:0] e;
    int lat;
    for (int k = 0; k < 24; k++) begin
      x = (k % 6 == 0) ? 32'hFFFFFFFF : $urandom;
      y = (k % 4 == 1) ? ~x : $urandom;
      c = 1'($urandom);
      e = ref_add(x, y, c);
      issue(x, y, c, lat);
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      total++; if ({cout, sum} !== e || lat !== 4) begin bad++; $display("FAIL rand%0d got=%h lat=%0d exp=%h lat=4", k, {cout, sum}, lat, e); end
      handshake;
    end
  endtask

`ifdef WIDE_ADD_SEQ_SUB_EN
  task automatic test_sub;
    int lat;
    op_sub = 1;
    issue(32'h80000000, 32'h00000001, 1'b0, lat);
    total++; if ({ovf, cout, sum} !== {2'b11, 32'h7FFFFFFF}) begin bad++; $display("FAIL t6_sub_ovf got=%b_%h exp=11_7fffffff", {ovf, cout}, sum); end
    handshake;
    op_sub = 1;
    issue(32'h5, 32'h5, 1'b1, lat);
    total++; if ({ovf, cout, sum} !== {2'b01, 32'h0}) begin bad++; $display("FAIL t6_sub_zero got=%b_%h exp=01_00000000", {ovf, cout}, sum); end
    handshake;
    op_sub = 0;
  endtask
`endif

  initial begin
    test_reset;
    test_directed;
    test_backpressure;
    test_back_to_back;
    test_reset_mid_run;
    test_random;
`ifdef WIDE_ADD_SEQ_SUB_EN
    test_sub;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
